// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 target with a byte-addressed register file.
//
// Lets an SPI initiator (the accelerometer front end) be exercised in loopback
// without the physical sensor. The command set is the accelerometer one:
// CMD_WRITE / CMD_READ, then an address byte, then data bytes. A fabric-side
// host port preloads and inspects registers, e.g. to inject fake samples.
//
// SCLK, SS and MOSI are asynchronous to clk_i. Each one is oversampled through
// a 2-flop synchronizer followed by a history flop.
//
// Build option:
//   SPI_RESPONDER_BURST_EN  defined: the DATA phase continues for as many bytes
//                           as the initiator clocks, auto-incrementing and
//                           wrapping the address.
//                           undefined (default): one data byte per transaction,
//                           after which the responder ignores the bus until SS
//                           rises.
//
// Ports:
//   clk_i           system clock (108 MHz)
//   reset_i         synchronous, active-high reset
//   sclk_i          SPI clock from the initiator (async)
//   mosi_i          serial data from the initiator (async)
//   ss_i            slave select, active-low (async)
//   miso_o          serial data to the initiator; 0 while synchronized SS is high
//   host_we_i       host write strobe
//   host_addr_i     host register address
//   host_wdata_i    host write data
//   host_rdata_o    reg[host_addr_i], one cycle of latency
//   spi_wr_valid_o  one-cycle pulse when an SPI write commits
//   spi_wr_addr_o   address of the committed SPI write
//   spi_wr_data_o   data of the committed SPI write
//   busy_o          synchronized SS is low and a transaction is in progress

module spi_responder #(
  parameter int unsigned ADDR_W    = 6,  // at most 8: addresses come from one byte
  parameter logic [7:0]  CMD_WRITE = 8'h0A,
  parameter logic [7:0]  CMD_READ  = 8'h0B
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sclk_i,
  input  logic              mosi_i,
  input  logic              ss_i,
  output logic              miso_o,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [7:0]        host_wdata_i,
  output logic [7:0]        host_rdata_o,
  output logic              spi_wr_valid_o,
  output logic [ADDR_W-1:0] spi_wr_addr_o,
  output logic [7:0]        spi_wr_data_o,
  output logic              busy_o
);

  localparam int unsigned       Depth   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] AddrOne = 1;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StIgnore
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers: bit 0 and 1 synchronize, bit 2 is the history flop.
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_q;
  logic [2:0] ss_q;
  logic [2:0] mosi_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk_q <= 3'b000;
      ss_q   <= 3'b111;
      mosi_q <= 3'b000;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      ss_q   <= {ss_q[1:0], ss_i};
      mosi_q <= {mosi_q[1:0], mosi_i};
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;
  logic ss_rise;
  logic mosi_bit;
  logic ss_sync;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_sync   = ss_q[1];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  // MOSI is stable for many clk cycles around an SCLK edge, so the history copy
  // is as good a sample as the synchronizer output.
  assign mosi_bit  = mosi_q[2];

  // ---------------------------------------------------------------------------
  // Arming: the SS chain resets to 1, so if the pin is low when reset drops the
  // chain would show a fake falling edge. A transaction may only start after a
  // genuinely high SS has been observed once the chain has been refilled.
  // ---------------------------------------------------------------------------
  logic [1:0] settle_q;
  logic       armed_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end
      if (settle_q == 2'd2 && ss_sync) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign ss_fall = armed_q & ss_q[2] & ~ss_q[1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic              mode_wr_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        rx_shift_q;
  logic              byte_done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        tx_shift_q;
  logic              miso_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        host_rdata_q;

  logic [7:0]        regs_q [Depth];

  logic [ADDR_W-1:0] rx_addr;
  logic              spi_we;

  assign rx_addr = rx_shift_q[ADDR_W-1:0];

  // An SS rise in the same cycle as byte_done aborts the byte: no commit.
  assign spi_we = ~reset_i & byte_done_q & ~ss_rise & mode_wr_q & (state_q == StData);

  // ---------------------------------------------------------------------------
  // Transaction FSM with the shift registers and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      mode_wr_q   <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      byte_done_q <= 1'b0;
      addr_q      <= '0;
      tx_shift_q  <= 8'h00;
      miso_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      wr_valid_q  <= 1'b0;
      byte_done_q <= 1'b0;
      miso_q      <= ss_sync ? 1'b0 : tx_shift_q[7];

      if (ss_rise) begin
        // End of transaction: drop any partial byte and any pending read data.
        state_q    <= StIdle;
        bit_cnt_q  <= 3'd0;
        tx_shift_q <= 8'h00;
      end else begin
        if (state_q != StIdle) begin
          if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[6:0], mosi_bit};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && state_q != StIgnore) begin
              byte_done_q <= 1'b1;
            end
          end
          // No shift on the fall right after a byte boundary, so the MSB that
          // was just loaded stays on MISO for the first rise of the next byte.
          if (sclk_fall && bit_cnt_q != 3'd0) begin
            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
          end
        end

        unique case (state_q)
          StIdle: begin
            if (ss_fall) begin
              state_q    <= StCmd;
              bit_cnt_q  <= 3'd0;
              tx_shift_q <= 8'h00;
            end
          end

          StCmd: begin
            if (byte_done_q) begin
              if (rx_shift_q == CMD_WRITE) begin
                mode_wr_q <= 1'b1;
                state_q   <= StAddr;
              end else if (rx_shift_q == CMD_READ) begin
                mode_wr_q <= 1'b0;
                state_q   <= StAddr;
              end else begin
                state_q <= StIgnore;
              end
            end
          end

          StAddr: begin
            if (byte_done_q) begin
              state_q <= StData;
              if (mode_wr_q) begin
                addr_q <= rx_addr;
              end else begin
                // Reads prefetch the first byte here; addr_q then points at
                // the byte to fetch at the next boundary.
                tx_shift_q <= regs_q[rx_addr];
                addr_q     <= rx_addr + AddrOne;
              end
            end
          end

          StData: begin
            if (byte_done_q) begin
              addr_q <= addr_q + AddrOne;
              if (mode_wr_q) begin
                wr_valid_q <= 1'b1;
                wr_addr_q  <= addr_q;
                wr_data_q  <= rx_shift_q;
              end
`ifdef SPI_RESPONDER_BURST_EN
              if (!mode_wr_q) begin
                tx_shift_q <= regs_q[addr_q];
              end
`else
              if (!mode_wr_q) begin
                tx_shift_q <= 8'h00;
              end
              state_q <= StIgnore;
`endif
            end
          end

          StIgnore: begin
            // Hold until SS rises.
          end

          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: not reset. The SPI write is issued last so it wins a
  // same-address collision with the host. Reads above see pre-write contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (host_we_i) begin
      regs_q[host_addr_i] <= host_wdata_i;
    end
    if (spi_we) begin
      regs_q[addr_q] <= rx_shift_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      host_rdata_q <= 8'h00;
    end else begin
      host_rdata_q <= regs_q[host_addr_i];
    end
  end

  assign miso_o         = miso_q;
  assign host_rdata_o   = host_rdata_q;
  assign spi_wr_valid_o = wr_valid_q;
  assign spi_wr_addr_o  = wr_addr_q;
  assign spi_wr_data_o  = wr_data_q;
  assign busy_o         = ~ss_sync & (state_q != StIdle);

endmodule
